// File: rtl/psk_symbol_mapper_pkg.sv
// Shared definitions for the BPSK symbol mapper: FSM state encoding,
// the byte width, and a constant clog2 helper used to size the
// per-symbol sample counter.
package psk_symbol_mapper_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam int BYTE_W = 8;

  // Ceiling log2 for v >= 2; evaluated at elaboration time only.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((v - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psk_symbol_mapper.sv
// Transmit BPSK symbol mapper: takes bytes over valid/ready, sends them
// MSB-first, and emits SPS two's-complement samples of +amp / -amp per bit,
// optionally differentially encoded.
// Ports: clk, rst (sync, active-high); amp (magnitude, MSB masked);
//   in_data/in_vld/in_rdy (byte stream in); out/out_vld (sample stream out,
//   registered); busy (byte in progress).
module psk_symbol_mapper
  import psk_symbol_mapper_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPS   = 8,
  parameter bit DIFF  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  amp,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic [WIDTH-1:0]  out,
  output logic              out_vld,
  output logic              busy
);

  localparam int SW  = clog2(SPS);
  localparam int BCW = clog2(BYTE_W);

  localparam logic [SW-1:0]    SAMP_LAST = SW'(SPS - 1);
  localparam logic [SW-1:0]    SAMP_ONE  = SW'(1);
  localparam logic [BCW-1:0]   BIT_LAST  = BCW'(BYTE_W - 1);
  localparam logic [BCW-1:0]   BIT_ONE   = BCW'(1);
  localparam logic [WIDTH-1:0] AMP_MASK  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]        state_q,    state_d;
  logic [BYTE_W-1:0] shreg_q,    shreg_d;
  logic [BCW-1:0]    bit_cnt_q,  bit_cnt_d;
  logic [SW-1:0]     samp_cnt_q, samp_cnt_d;
  logic              ref_sym_q,  ref_sym_d;
  logic [WIDTH-1:0]  amp_q,      amp_d;
  logic [WIDTH-1:0]  out_q,      out_d;
  logic              out_vld_q,  out_vld_d;
  logic              busy_q,     busy_d;

  logic xfer;
  logic bit_start;
  logic cur_bit;
  logic new_sym;
  logic cur_sym;

  // Masking the magnitude MSB beforehand means the negation cannot overflow.
  function automatic logic [WIDTH-1:0] apply_sign(input logic sym,
                                                  input logic [WIDTH-1:0] mag);
    return sym ? mag : (~mag + ONE);
  endfunction

  // Ready depends only on registered state, never on in_vld.
  assign in_rdy = (state_q == ST_IDLE) ||
                  ((bit_cnt_q == BIT_LAST) && (samp_cnt_q == SAMP_LAST));
  assign xfer   = in_vld && in_rdy;

  // Symbol currently on the air: in differential mode ref_sym already holds
  // it; in absolute mode it is simply the bit at the top of the shifter.
  assign cur_sym = DIFF ? ref_sym_q : shreg_q[BYTE_W-1];

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    samp_cnt_d = samp_cnt_q;
    ref_sym_d  = ref_sym_q;
    amp_d      = amp_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    busy_d     = busy_q;
    bit_start  = 1'b0;
    cur_bit    = 1'b0;
    new_sym    = 1'b0;

    if (xfer) begin
      state_d    = ST_SEND;
      shreg_d    = in_data;
      bit_cnt_d  = '0;
      samp_cnt_d = '0;
      bit_start  = 1'b1;
    end else if (state_q == ST_SEND) begin
      if (samp_cnt_q == SAMP_LAST) begin
        samp_cnt_d = '0;
        shreg_d    = {shreg_q[BYTE_W-2:0], 1'b0};
        bit_cnt_d  = bit_cnt_q + BIT_ONE;
        if (bit_cnt_q == BIT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          bit_start = 1'b1;
        end
      end else begin
        samp_cnt_d = samp_cnt_q + SAMP_ONE;
      end
    end

    // The bit about to start is always the MSB of the next shifter value.
    cur_bit = shreg_d[BYTE_W-1];
    new_sym = DIFF ? (ref_sym_q ^ cur_bit) : cur_bit;

    if (bit_start) begin
      if (DIFF) ref_sym_d = new_sym;
      amp_d = amp & AMP_MASK;
      out_d = apply_sign(new_sym, amp_d);
    end else begin
      out_d = apply_sign(cur_sym, amp_q);
    end

    if (state_d == ST_IDLE) out_d = '0;
    out_vld_d = (state_d == ST_SEND);
    busy_d    = (state_d == ST_SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      samp_cnt_q <= '0;
      ref_sym_q  <= 1'b1;
      amp_q      <= '0;
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      ref_sym_q  <= ref_sym_d;
      amp_q      <= amp_d;
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      busy_q     <= busy_d;
    end
  end

  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign busy    = busy_q;

endmodule

// File: doc/psk_symbol_mapper.md
# psk_symbol_mapper

Transmit-side BPSK symbol mapper: accepts data bytes over a valid/ready stream, serializes them MSB-first and, for each bit, emits SPS consecutive two's-complement baseband samples of +amp or -amp, with optional differential encoding. It is the transmit counterpart of the receive-path magnitude stage: that stage strips the sign from samples, and this block applies a data-driven sign to a magnitude. Its output feeds the pulse-shaping/DAC path.

## Interface
- WIDTH, 16: sample width in bits, two's complement.
- SPS, 8: samples per symbol; must be ≥ 2.
- DIFF, 1: 1 = differential BPSK (a bit of 1 flips the phase); 0 = absolute (1 → +amp, 0 → -amp).

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- amp  in  WIDTH  unsigned magnitude; bit WIDTH-1 is masked to 0.
- in_data  in  8  byte to transmit.
- in_vld  in  1  in_data is valid.
- in_rdy  out  1  block accepts in_data this cycle (combinational from state).
- out  out  WIDTH  signed sample (registered).
- out_vld  out  1  out holds a valid sample (registered).
- busy  out  1  byte in progress (registered).

## Operation
- States: IDLE, SEND. Registers: shreg[7:0], bit_cnt[2:0], samp_cnt[clog2(SPS)-1:0], ref_sym, amp_q.
- Handshake: a byte transfers on a cycle where in_vld & in_rdy. in_rdy = (state==IDLE) | (bit_cnt==7 & samp_cnt==SPS-1). in_data is ignored unless a transfer occurs.
- On transfer: shreg ← in_data, bit_cnt ← 0, samp_cnt ← 0, state ← SEND, and the first sample of bit 7 is registered to out.
- Per bit start, with b the current MSB: sym = DIFF ? ref_sym ^ b : b; ref_sym ← sym when DIFF. amp_q ← {1'b0, amp[WIDTH-2:0]}. amp is latched only at bit start, so a mid-symbol change of amp does not affect the current symbol.
- Sample value: sym = 1 → amp_q; sym = 0 → ~amp_q + 1. Masking bit WIDTH-1 guarantees that negation never overflows.
- samp_cnt counts 0..SPS-1. At wrap, shreg shifts left and bit_cnt increments. After bit_cnt 7 wraps: if a new transfer occurs, continue in SEND; otherwise state ← IDLE.
- In IDLE: out = 0, out_vld = 0, busy = 0.
- ref_sym persists across idle gaps and is reset only by rst.

## Timing
- Reset values: out = 0, out_vld = 0, busy = 0, state = IDLE, ref_sym = 1 (+ phase), shreg = 0, both counters = 0. in_rdy = 1 in the cycle after reset is released.
- Latency: for a transfer in cycle N, the first sample appears on out in cycle N+1. The byte occupies cycles N+1 .. N+8·SPS with out_vld = 1 throughout.
- Back-to-back: in_rdy is high in cycle N+8·SPS. A transfer in that cycle puts the next byte's first sample in cycle N+8·SPS+1, with no bubble and no gap in out_vld.
- If no transfer occurs at the last sample: out_vld = 0 and out = 0 in the next cycle, then the block stays in IDLE.
- in_vld may stay high without a transfer; the block holds no combinational path from in_vld to in_rdy.
- rst asserted mid-byte: next cycle all registers return to reset values, and the partial byte is discarded and not resumed. rst has priority over a simultaneous transfer.

## Structure
- Shared package: state encoding (IDLE = 0, SEND = 1), the byte width constant 8, and a clog2 function used for the samp_cnt width.
- Single module with no sub-module. The sign application is a small combinational function inside the module.

## Test plan
- WIDTH=16, SPS=4, DIFF=0, amp=0x1000, byte 0xA5 → 4×0x1000, 4×0xF000, 4×0x1000, 4×0xF000, 4×0xF000, 4×0x1000, 4×0xF000, 4×0x1000. out_vld is high for exactly 32 cycles, starting 1 cycle after the transfer.
- DIFF=1, fresh reset, bytes 0x80 then 0x80 back-to-back → first byte 32×0xF000, second byte 32×0x1000. 64 contiguous valid samples, with in_rdy pulsing exactly at sample 31.
- DIFF=0, amp=0xFFFF, byte 0xF0 → 16×0x7FFF, then 16×0x8001 (masking verified).
- amp changed from 0x1000 to 0x2000 at sample 2 of bit 7 (SPS=4, DIFF=0, byte 0xFF) → bit 7 stays at 0x1000 for all 4 samples, bit 6 onward is 0x2000.
- rst asserted at sample 10 of byte 0x55 → next cycle out = 0, out_vld = 0, busy = 0, in_rdy = 1. A new byte 0x00 with DIFF=1 then yields 32×0x1000, confirming ref_sym was reset to 1.
- in_vld held low for 5 cycles after a byte → out_vld = 0 and out = 0 for those cycles. The next byte starts 1 cycle after its transfer, and in DIFF mode ref_sym is preserved across the gap.
